// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of the DCCM SRAM macro.
// Port 0 (core LSU adapter) and port 1 (DMA/debug adapter) each use the
// adapter-side req/gnt/rvalid handshake. The arbiter grants one access per
// cycle, drives the SRAM's active-low chip-select / write-enable and byte mask
// in the same cycle, and routes read data back to the issuing port
// ReadLatency cycles later.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   pN_req_i / pN_gnt_o     request / same-cycle grant for port N
//   pN_we_i                 1 = write, 0 = read
//   pN_addr_i               word address
//   pN_wdata_i, pN_wmask_i  write data and bit-level write mask
//   pN_rvalid_o, pN_rdata_o read response (rdata is '0 when not valid)
//   sram_*                  SRAM macro pins (csb/web active low, byte mask)
module dmem_arbiter #(
    parameter int unsigned Aw          = 10,
    parameter int unsigned Dw          = 32,
    parameter int unsigned ReadLatency = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              p0_req_i,
    output logic              p0_gnt_o,
    input  logic              p0_we_i,
    input  logic [Aw-1:0]     p0_addr_i,
    input  logic [Dw-1:0]     p0_wdata_i,
    input  logic [Dw-1:0]     p0_wmask_i,
    output logic              p0_rvalid_o,
    output logic [Dw-1:0]     p0_rdata_o,

    input  logic              p1_req_i,
    output logic              p1_gnt_o,
    input  logic              p1_we_i,
    input  logic [Aw-1:0]     p1_addr_i,
    input  logic [Dw-1:0]     p1_wdata_i,
    input  logic [Dw-1:0]     p1_wmask_i,
    output logic              p1_rvalid_o,
    output logic [Dw-1:0]     p1_rdata_o,

    output logic              sram_csb_o,
    output logic              sram_web_o,
    output logic [Dw/8-1:0]   sram_wmask_o,
    output logic [Aw-1:0]     sram_addr_o,
    output logic [Dw-1:0]     sram_din_o,
    input  logic [Dw-1:0]     sram_dout_i
);

    localparam int unsigned Bw = Dw / 8;

    typedef enum logic {
        PRIO_P0 = 1'b0,
        PRIO_P1 = 1'b1
    } prio_e;

    prio_e                  prio_q;
    prio_e                  prio_d;
    logic                   gnt0;
    logic                   gnt1;
    logic                   gnt_any;
    logic                   win_we;
    logic [Dw-1:0]          win_wmask;
    logic [Bw-1:0]          win_byte_en;
    logic                   rd_issue;
    logic [ReadLatency-1:0] pipe_valid;
    logic [ReadLatency-1:0] pipe_port;
    logic                   rsp_valid;
    logic                   rsp_port;

    // Priority pointer register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= PRIO_P0;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Grant decision and next priority: the winner drops to lowest priority
    always_comb begin
        prio_d = prio_q;
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        if (!rst_i) begin
            if (p0_req_i && (!p1_req_i || prio_q == PRIO_P0)) begin
                gnt0 = 1'b1;
            end else if (p1_req_i) begin
                gnt1 = 1'b1;
            end
        end
        if (gnt0) begin
            prio_d = PRIO_P1;
        end else if (gnt1) begin
            prio_d = PRIO_P0;
        end
    end

    assign gnt_any  = gnt0 | gnt1;
    assign p0_gnt_o = gnt0;
    assign p1_gnt_o = gnt1;

    // Collapse the bit mask of the winner into per-byte enables
    for (genvar b = 0; b < Bw; b++) begin : g_byte
        assign win_byte_en[b] = |win_wmask[8*b +: 8];
    end

    // SRAM pin mux; address/data park on port 0 when idle
    always_comb begin
        sram_csb_o   = 1'b1;
        sram_web_o   = 1'b1;
        sram_wmask_o = '0;
        sram_addr_o  = p0_addr_i;
        sram_din_o   = p0_wdata_i;
        win_we       = 1'b0;
        win_wmask    = p0_wmask_i;
        if (gnt1) begin
            sram_addr_o = p1_addr_i;
            sram_din_o  = p1_wdata_i;
            win_we      = p1_we_i;
            win_wmask   = p1_wmask_i;
        end else if (gnt0) begin
            win_we      = p0_we_i;
        end
        if (gnt_any) begin
            sram_csb_o = 1'b0;
            sram_web_o = ~win_we;
            if (win_we) begin
                sram_wmask_o = win_byte_en;
            end
        end
    end

    // Response tracker: only granted reads enter as valid
    assign rd_issue = gnt_any & ~win_we;

    if (ReadLatency > 1) begin : g_shift
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                pipe_valid <= '0;
                pipe_port  <= '0;
            end else begin
                pipe_valid <= {pipe_valid[ReadLatency-2:0], rd_issue};
                pipe_port  <= {pipe_port[ReadLatency-2:0], gnt1};
            end
        end
    end else begin : g_single
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                pipe_valid <= '0;
                pipe_port  <= '0;
            end else begin
                pipe_valid <= rd_issue;
                pipe_port  <= gnt1;
            end
        end
    end

    // Final stage routes SRAM read data to the recorded port; silent in reset
    assign rsp_valid   = pipe_valid[ReadLatency-1] & ~rst_i;
    assign rsp_port    = pipe_port[ReadLatency-1];
    assign p0_rvalid_o = rsp_valid & ~rsp_port;
    assign p1_rvalid_o = rsp_valid & rsp_port;
    assign p0_rdata_o  = p0_rvalid_o ? sram_dout_i : '0;
    assign p1_rdata_o  = p1_rvalid_o ? sram_dout_i : '0;

endmodule
